pipelined_rca_adder: RTL and testbench

//  Parametrised, pipelined ripple-carry add/subtract unit; successor to the fixed 4-bit RCA.

---
 rtl/pipelined_rca_adder.sv | 115 +++++++++++
 tb/tb_pipelined_rca_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry add/subtract unit.
// One CHUNK-wide ripple adder per stage, valid/ready on both sides.
module pipelined_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             w_stall;
  logic             w_en;
  logic             w_c0;
  logic [WIDTH-1:0] w_b_eff;

  assign w_b_eff  = sub ? ~b : b;
  assign w_c0     = sub | cin;
  assign w_stall  = out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      w_ia;
    logic [REM-1:0]      w_ib;
    logic                w_ic;
    logic                w_iv;
    logic [CHUNK:0]      w_add;
    logic [LO+CHUNK-1:0] w_s;

    logic                r_v;
    logic                r_c;
    logic [LO+CHUNK-1:0] r_s;

    if (k == 0) begin : g_head
      assign w_ia = a;
      assign w_ib = w_b_eff;
      assign w_ic = w_c0;
      assign w_iv = in_valid;
      assign w_s  = w_add[CHUNK-1:0];
    end else begin : g_body
      assign w_ia = g_st[k-1].g_fw.r_a;
      assign w_ib = g_st[k-1].g_fw.r_b;
      assign w_ic = g_st[k-1].r_c;
      assign w_iv = g_st[k-1].r_v;
      assign w_s  = {w_add[CHUNK-1:0], g_st[k-1].r_s};
    end

    assign w_add = {1'b0, w_ia[CHUNK-1:0]}
                 + {1'b0, w_ib[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, w_ic};

    // Register this chunk's sum, carry and valid; hold on stall.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_en) begin
        r_v <= w_iv;
        r_c <= w_add[CHUNK];
        r_s <= w_s;
      end
    end

    if (k < STAGES - 1) begin : g_fw
      logic [REM-CHUNK-1:0] r_a;
      logic [REM-CHUNK-1:0] r_b;

      // Carry the not-yet-added operand chunks to the next stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_ia[REM-1:CHUNK];
          r_b <= w_ib[REM-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic r_ov;

      // Carry into MSB is a^b^s at that bit; XOR with carry out.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ov <= 1'b0;
        end else if (w_en) begin
          r_ov <= w_ia[CHUNK-1] ^ w_ib[CHUNK-1]
                ^ w_add[CHUNK-1] ^ w_add[CHUNK];
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign sum       = g_st[STAGES-1].r_s;
  assign cout      = g_st[STAGES-1].r_c;
  assign overflow  = g_st[STAGES-1].g_tail.r_ov;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder.
// Random and directed ops against an integer reference model.
module tb_pipelined_rca_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  pipelined_rca_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_out = 0;
  int n_acc = 0;
  bit mon_en  = 1'b0;
  bit chk_lat = 1'b1;
  bit held    = 1'b0;
  logic [18:0] held_v;

  typedef struct {
    logic [17:0] e;
    int          acc;
  } ent_t;
  ent_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic ci,
                                        input logic s);
    int ua, ub, sa, sb, ur, sr;
    logic co, ov;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    if (s) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + int'(ci);
      sr = sa + sb + int'(ci);
      co = (ur > 65535);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, ur[15:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (mon_en) begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (held)
        chk("hold", {out_valid, overflow, cout, sum}, held_v);
      held = 1'b0;
      if (out_valid && !out_ready) begin
        held   = 1'b1;
        held_v = {out_valid, overflow, cout, sum};
      end
      if (out_valid && out_ready) begin
        chk("q_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          ent_t en;
          en = q.pop_front();
          chk("res", {overflow, cout, sum}, en.e);
          if (chk_lat) chk("lat", cyc - en.acc, S);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{model(a, b, cin, sub), cyc});
        n_acc++;
      end
    end
  end

  task automatic rnd_in(input bit v);
    in_valid = v;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic directed(input string tag,
                          input logic [15:0] x,
                          input logic [15:0] y,
                          input logic ci,
                          input logic s,
                          input logic [17:0] exp);
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = x; b = y; cin = ci; sub = s;
    @(posedge clk); #1;
    rnd_in(1'b0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, S);
    chk(tag, {overflow, cout, sum}, exp);
  endtask

  initial begin
    int base, cnt;
    rst = 1'b1;
    out_ready = 1'b1;
    rnd_in(1'b0);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    mon_en = 1'b1;

    // Fill and stall, then reset with ops in flight.
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      rnd_in(1'b1);
    end
    @(posedge clk); #1;
    rnd_in(1'b0);
    @(negedge clk);
    chk("fill_stall", out_valid, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("post_rst_valid", cnt, 0);

    directed("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    directed("sub_ov", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    directed("sub_neg", 16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    directed("add_ov", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    directed("cin", 16'h0000, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0001});
    directed("sub_cin", 16'h0005, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0002});

    // Back-to-back streaming with latency check.
    repeat (4) @(posedge clk);
    base = n_out;
    chk_lat = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      rnd_in(1'b1);
    end
    @(posedge clk); #1;
    rnd_in(1'b0);
    repeat (8) @(posedge clk);
    chk("stream_cnt", n_out - base, 100);

    // Random backpressure and bubbles.
    chk_lat = 1'b0;
    base = n_out;
    cnt = n_acc;
    repeat (300) begin
      @(posedge clk); #1;
      rnd_in($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom);
    end
    @(posedge clk); #1;
    rnd_in(1'b0);
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_drain", q.size(), 0);
    chk("bp_cnt", n_out - base, n_acc - cnt);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
